// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer for the pixel array: erase, expose, convert (ADC code ramp),
// two read phases, then a valid/ready hand-off of the captured 32-bit frame word.
module pixel_frame_sequencer #(
   parameter int ERASE_CYCLES = 4,
   parameter int READ_CYCLES  = 2,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      cfg_expose,
   output logic             erase,
   output logic             expose,
   output logic             convert,
   output logic             read0,
   output logic             read1,
   output logic [CNT_W-1:0] adc_code,
   input  logic [7:0]       data_in1,
   input  logic [7:0]       data_in2,
   output logic [31:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             frame_done,
   output logic [2:0]       state_dbg
);

   // Handshake: a word transfers in any cycle where out_valid and out_ready are
   // both high; out_valid is a flop, so it never depends on out_ready in-cycle.
   typedef enum logic [2:0] {
      S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ0, S_READ1, S_OUT
   } state_t;

   localparam logic [31:0] CONV_LAST  = (32'd1 << CNT_W) - 32'd1;
   localparam logic [31:0] ERASE_LAST = 32'(ERASE_CYCLES - 1);
   localparam logic [31:0] READ_LAST  = 32'(READ_CYCLES - 1);

   state_t      state, state_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic [31:0] phase_last;
   logic [15:0] expose_len;

   assign state_dbg = state;

   always_comb begin
      phase_last = '0;
      case (state)
         S_ERASE:           phase_last = ERASE_LAST;
         S_EXPOSE:          phase_last = {16'd0, expose_len} - 32'd1;
         S_CONVERT:         phase_last = CONV_LAST;
         S_READ0, S_READ1:  phase_last = READ_LAST;
         default:           phase_last = '0;
      endcase
   end

   // cnt is the 0-based cycle index within the current timed phase.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 32'd1;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start) state_nxt = S_ERASE;
         end
         S_OUT: begin
            cnt_nxt = '0;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: begin
            if (cnt == phase_last) begin
               cnt_nxt = '0;
               case (state)
                  S_ERASE:   state_nxt = S_EXPOSE;
                  S_EXPOSE:  state_nxt = S_CONVERT;
                  S_CONVERT: state_nxt = S_READ0;
                  S_READ0:   state_nxt = S_READ1;
                  S_READ1:   state_nxt = S_OUT;
                  default:   state_nxt = S_IDLE;
               endcase
            end
         end
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         expose_len <= 16'd1;
         erase      <= 1'b0;
         expose     <= 1'b0;
         convert    <= 1'b0;
         read0      <= 1'b0;
         read1      <= 1'b0;
         adc_code   <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         erase      <= (state_nxt == S_ERASE);
         expose     <= (state_nxt == S_EXPOSE);
         convert    <= (state_nxt == S_CONVERT);
         read0      <= (state_nxt == S_READ0);
         read1      <= (state_nxt == S_READ1);
         adc_code   <= (state_nxt == S_CONVERT) ? cnt_nxt[CNT_W-1:0] : '0;
         out_valid  <= (state_nxt == S_OUT);
         busy       <= (state_nxt != S_IDLE);
         frame_done <= (state == S_OUT) && out_ready;
         if (state == S_IDLE && start)
            expose_len <= (cfg_expose == 16'd0) ? 16'd1 : cfg_expose;
         if (state == S_READ0 && cnt == phase_last)
            out_data[15:0] <= {data_in2, data_in1};
         if (state == S_READ1 && cnt == phase_last)
            out_data[31:16] <= {data_in2, data_in1};
      end
   end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Randomized bench for pixel_frame_sequencer; expected outputs come from a
// cycle-offset model of the frame timeline driven by the same input stream.
module tb_pixel_frame_sequencer;

   localparam int E  = 4;
   localparam int R  = 2;
   localparam int CW = 8;
   localparam int C  = 1 << CW;
   localparam int FRAME_LIMIT = 3000;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1, start = 1'b0, out_ready = 1'b0;
   logic [15:0]   cfg_expose = '0;
   logic [7:0]    data_in1 = '0, data_in2 = '0;
   logic          erase, expose, convert, read0, read1, out_valid, busy, frame_done;
   logic [CW-1:0] adc_code;
   logic [31:0]   out_data;
   logic [2:0]    state_dbg;

   pixel_frame_sequencer #(.ERASE_CYCLES(E), .READ_CYCLES(R), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_expose(cfg_expose),
      .erase(erase), .expose(expose), .convert(convert), .read0(read0), .read1(read1),
      .adc_code(adc_code), .data_in1(data_in1), .data_in2(data_in2),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
   );

   int checks = 0, fails = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d act=%h exp=%h", tag, cyc, act, exp);
      end
   endtask

   // reference model: frame timeline as offsets from the accepting cycle
   int          cyc = 0;
   bit          m_active = 0, m_done = 0;
   int          m_t0 = 0, m_n = 1;
   logic [31:0] m_word = '0;
   int          model_words = 0, dut_words = 0;
   logic [7:0]  e_ctl;
   logic [31:0] e_adc;
   bit          e_r0, e_r1, e_r0_last, e_r1_last;

   // scenario controls
   bit          chk_en = 0, rst_drv = 1, start_drv = 0, rand_start = 0, chain = 0;
   bit          fixed_data = 0, rst_on_adc = 0, ov_prev = 0;
   int          cfg_drv = 0, ready_mode = 0, first_ov_cyc = 0, expose_cnt = 0;

   task automatic predict();
      int d, px, pc, p0, p1;
      e_ctl = '0; e_adc = '0; e_r0 = 0; e_r1 = 0; e_r0_last = 0; e_r1_last = 0;
      if (m_active) begin
         d  = cyc - m_t0;
         px = E + m_n; pc = px + C; p0 = pc + R; p1 = p0 + R;
         e_ctl[1] = 1'b1;
         if (d <= E)        e_ctl[7] = 1'b1;
         else if (d <= px)  e_ctl[6] = 1'b1;
         else if (d <= pc) begin e_ctl[5] = 1'b1; e_adc = 32'(d - px - 1); end
         else if (d <= p0) begin e_ctl[4] = 1'b1; e_r0 = 1; e_r0_last = (d == p0); end
         else if (d <= p1) begin e_ctl[3] = 1'b1; e_r1 = 1; e_r1_last = (d == p1); end
         else               e_ctl[2] = 1'b1;
      end
      e_ctl[0] = m_done;
   endtask

   task automatic model_edge();
      bit done_new = 0;
      if (reset) begin
         m_active = 0; m_done = 0; m_word = '0;
         return;
      end
      if (m_active) begin
         if (e_r0_last) m_word[15:0]  = {data_in2, data_in1};
         if (e_r1_last) m_word[31:16] = {data_in2, data_in1};
         if (e_ctl[2] && out_ready) begin
            m_active = 0; done_new = 1; model_words++;
         end
      end else if (start) begin
         m_active = 1; m_t0 = cyc;
         m_n = (cfg_expose == 16'd0) ? 1 : int'(cfg_expose);
      end
      m_done = done_new;
   endtask

   // driver: one clock cycle, inputs applied just after the rising edge
   task automatic step();
      int ov_start;
      @(posedge clk);
      cyc++;
      #1;
      predict();
      reset = rst_drv;
      if (rst_on_adc && e_ctl[5] && e_adc == 32'h80) begin
         reset = 1'b1; rst_on_adc = 0;
      end
      start = start_drv | (rand_start && m_active && $urandom_range(0, 2) == 0);
      if (chain && m_done) begin start = 1'b1; chain = 0; end
      cfg_expose = m_active ? 16'($urandom) : 16'(cfg_drv);
      data_in1 = 8'($urandom); data_in2 = 8'($urandom);
      if (fixed_data && e_r0) begin data_in1 = 8'h11; data_in2 = 8'h22; end
      if (fixed_data && e_r1) begin data_in1 = 8'h33; data_in2 = 8'h44; end
      ov_start = m_t0 + E + m_n + C + 2 * R + 1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = (cyc >= ov_start + 20);
      endcase
      @(negedge clk);
      if (chk_en) begin
         check_eq("ctl", {24'd0, erase, expose, convert, read0, read1, out_valid, busy, frame_done},
                  {24'd0, e_ctl});
         check_eq("adc_code", {24'd0, adc_code}, e_adc);
         check_eq("out_data", out_data, m_word);
      end
      if (expose) expose_cnt++;
      if (out_valid && !ov_prev) first_ov_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) dut_words++;
      model_edge();
   endtask

   task automatic run_frame(input int cfg, output int t0);
      int guard = 0;
      cfg_drv = cfg; expose_cnt = 0;
      start_drv = 1; step(); start_drv = 0;
      t0 = m_t0;
      while ((m_active || m_done) && guard < FRAME_LIMIT) begin
         step(); guard++;
      end
      if (guard >= FRAME_LIMIT) check_eq("frame_timeout", {31'd0, m_active}, 32'd0);
      repeat (2) step();
   endtask

   initial begin
      int t0;
      rst_drv = 1;
      step();
      chk_en = 1;
      step();
      rst_drv = 0;
      repeat (3) step();

      // basic frame with known read data
      fixed_data = 1; ready_mode = 0;
      run_frame(10, t0);
      check_eq("basic_latency", 32'(first_ov_cyc - t0), 32'd275);
      check_eq("basic_word", out_data, 32'h44332211);
      check_eq("basic_expose_len", 32'(expose_cnt), 32'd10);
      fixed_data = 0;

      // backpressure: consumer stalls 20 cycles after out_valid
      ready_mode = 2;
      run_frame(5, t0);

      // starts during the frame, random ready
      ready_mode = 1; rand_start = 1;
      run_frame(7, t0);
      rand_start = 0; ready_mode = 0;

      // zero exposure treated as one cycle
      run_frame(0, t0);
      check_eq("zero_expose_len", 32'(expose_cnt), 32'd1);

      // back-to-back: start in the frame_done cycle
      chain = 1;
      run_frame(3, t0);

      // reset at adc_code 0x80, then a fresh full frame
      rst_on_adc = 1;
      run_frame(4, t0);
      check_eq("reset_no_word", out_data, 32'd0);
      fixed_data = 1;
      run_frame(10, t0);
      check_eq("post_reset_word", out_data, 32'h44332211);
      fixed_data = 0;

      // random frames
      for (int i = 0; i < 4; i++) begin
         ready_mode = 1; rand_start = 1;
         run_frame(int'($urandom_range(0, 15)), t0);
      end
      rand_start = 0;

      check_eq("word_count", 32'(dut_words), 32'(model_words));
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
